barrel_rotl_pipe: RTL and testbench

- Pipelined left-rotate barrel shifter. It is the inverse direction of the team's combinational right-rotate shifter.
- Data `i_a` is rotated left by `i_k` positions through log2(DW) registered stages: rotate-by-4, then rotate-by-2, then rotate-by-1 for DW=8.
- Valid/ready handshake on both sides, with full backpressure support.
- Sits on the datapath's "un-rotate" side: rotl(rotr(a,k),k) == a.

---
 rtl/barrel_pkg.sv | 10 +
 rtl/rotl_stage.sv | 35 +++
 rtl/barrel_rotl_pipe.sv | 46 ++++
 tb/tb_barrel_rotl_pipe.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// barrel_pkg: shared defaults and reference left-rotate for the rotate datapath
package barrel_pkg;
  localparam int DW_DEF = 8;
  localparam int SW_DEF = 3;
  function automatic logic [DW_DEF-1:0] rotl(input logic [DW_DEF-1:0] data, input logic [SW_DEF-1:0] amt);
    logic [2*DW_DEF-1:0] t;
    t = {data, data} << amt;
    return t[2*DW_DEF-1:DW_DEF];
  endfunction
endpackage

// File: rtl/rotl_stage.sv
// rotl_stage: one registered rotate-left-by-SH stage with valid/ready flow control
module rotl_stage
  import barrel_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = $clog2(DW),
  parameter int SH = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_a,
  input  logic [SW-1:0] i_k,
  input  logic          i_sel,
  input  logic          i_ready,
  output logic          o_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_y,
  output logic [SW-1:0] o_k
);
  logic [DW-1:0] rot;
  assign rot = {i_a[DW-SH-1:0], i_a[DW-1:DW-SH]};
  assign o_ready = !o_valid || i_ready;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_y     <= '0;
      o_k     <= '0;
    end else if (o_ready) begin
      o_valid <= i_valid;
      o_y     <= i_sel ? rot : i_a;
      o_k     <= i_k;
    end
  end
endmodule

// File: rtl/barrel_rotl_pipe.sv
// barrel_rotl_pipe: pipelined left-rotate barrel shifter with full backpressure
module barrel_rotl_pipe
  import barrel_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = $clog2(DW)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_a,
  input  logic [SW-1:0] i_k,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_y,
  output logic [SW-1:0] o_k
);
  logic          vld [SW+1];
  logic          rdy [SW+1];
  logic [DW-1:0] dat [SW+1];
  logic [SW-1:0] amt [SW+1];
  assign vld[0]  = i_valid;
  assign dat[0]  = i_a;
  assign amt[0]  = i_k;
  assign rdy[SW] = i_ready;
  assign o_ready = rdy[0];
  assign o_valid = vld[SW];
  assign o_y     = dat[SW];
  assign o_k     = amt[SW];
  for (genvar s = 0; s < SW; s++) begin : g_stage
    rotl_stage #(.DW(DW), .SW(SW), .SH(1 << (SW - 1 - s))) u_stage (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (vld[s]),
      .i_a     (dat[s]),
      .i_k     (amt[s]),
      .i_sel   (amt[s][SW-1-s]),
      .i_ready (rdy[s+1]),
      .o_ready (rdy[s]),
      .o_valid (vld[s+1]),
      .o_y     (dat[s+1]),
      .o_k     (amt[s+1])
    );
  end
endmodule

// File: tb/tb_barrel_rotl_pipe.sv
// tb_barrel_rotl_pipe: directed and random checks of the pipelined left-rotate shifter
module tb_barrel_rotl_pipe;
  import barrel_pkg::*;
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_a = '0;
  logic [2:0] i_k = '0;
  logic       o_valid;
  logic       i_ready = 1'b1;
  logic [7:0] o_y;
  logic [2:0] o_k;
  int n_vec = 0;
  int n_err = 0;
  typedef struct packed {logic [2:0] k; logic [7:0] y;} exp_t;
  exp_t q[$];

  barrel_rotl_pipe #(.DW(8)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_k     (i_k),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_y     (o_y),
    .o_k     (o_k)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotr(input logic [7:0] a, input logic [2:0] k);
    logic [15:0] t;
    t = {a, a} >> k;
    return t[7:0];
  endfunction

  initial begin
    logic       stall_q = 1'b0;
    logic [7:0] y_q = '0;
    logic [2:0] k_q = '0;
    exp_t       e;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        q.delete();
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("hold_v", 32'(o_valid), 32'd1);
          chk("hold_y", 32'(o_y), 32'(y_q));
          chk("hold_k", 32'(o_k), 32'(k_q));
        end
        if (i_valid && o_ready) q.push_back({i_k, rotl(i_a, i_k)});
        if (o_valid && i_ready) begin
          if (q.size() == 0) chk("sb_extra", 32'(o_y), 32'hffff_ffff);
          else begin
            e = q.pop_front();
            chk("sb_y", 32'(o_y), 32'(e.y));
            chk("sb_k", 32'(o_k), 32'(e.k));
          end
        end
        stall_q = o_valid && !i_ready;
        y_q = o_y;
        k_q = o_k;
      end
    end
  end

  task automatic single(input logic [7:0] a, input logic [2:0] k, input logic [7:0] y);
    @(posedge i_clk); #1;
    i_valid = 1'b1; i_a = a; i_k = k;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("lat_early", 32'(o_valid), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    chk("lat_valid", 32'(o_valid), 32'd1);
    chk("single_y", 32'(o_y), 32'(y));
    chk("single_k", 32'(o_k), 32'(k));
  endtask

  initial begin
    logic [7:0] beats [4];
    logic [7:0] av [20];
    logic [2:0] kv;
    int b;
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_y", 32'(o_y), 32'd0);
    chk("rst_k", 32'(o_k), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'd1);

    single(8'h81, 3'd1, 8'h03);
    single(8'hA5, 3'd4, 8'h5A);
    single(8'h01, 3'd7, 8'h80);
    single(8'h3C, 3'd0, 8'h3C);

    for (int i = 0; i < 259; i++) begin
      @(posedge i_clk); #1;
      i_valid = i < 256;
      i_a = 8'(i);
      i_k = 3'(i);
      @(negedge i_clk);
      if (i >= 3) chk("stream_cont", 32'(o_valid), 32'd1);
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge i_clk);

    b = 0;
    for (int j = 0; j < 6; j++) begin
      @(posedge i_clk); #1;
      i_ready = 1'b0; i_valid = 1'b1; i_a = beats[b]; i_k = 3'd1;
      @(negedge i_clk);
      if (o_ready) b++;
    end
    chk("bp_accepted", 32'(b), 32'd3);
    chk("bp_ready", 32'(o_ready), 32'd0);
    chk("bp_hold_y", 32'(o_y), 32'h22);
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("bp_rel_ready", 32'(o_ready), 32'd1);
    chk("bp_out0", 32'(o_y), 32'h22);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("bp_v1", 32'(o_valid), 32'd1);
    chk("bp_out1", 32'(o_y), 32'h44);
    @(negedge i_clk);
    chk("bp_v2", 32'(o_valid), 32'd1);
    chk("bp_out2", 32'(o_y), 32'h66);
    @(negedge i_clk);
    chk("bp_v3", 32'(o_valid), 32'd1);
    chk("bp_out3", 32'(o_y), 32'h88);
    @(negedge i_clk);
    chk("bp_empty", 32'(o_valid), 32'd0);

    for (int i = 0; i < 23; i++) begin
      @(posedge i_clk); #1;
      if (i < 20) begin
        av[i] = 8'($urandom);
        kv = 3'($urandom);
        i_valid = 1'b1; i_a = rotr(av[i], kv); i_k = kv;
      end else i_valid = 1'b0;
      @(negedge i_clk);
      if (i >= 3) begin
        chk("inv_v", 32'(o_valid), 32'd1);
        chk("inv_y", 32'(o_y), 32'(av[i-3]));
      end
    end

    for (int j = 0; j < 3; j++) begin
      @(posedge i_clk); #1;
      i_ready = 1'b0; i_valid = 1'b1; i_a = 8'h50 + 8'(j); i_k = 3'(j + 1);
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("mid_rst_v", 32'(o_valid), 32'd0);
    chk("mid_rst_y", 32'(o_y), 32'd0);
    chk("mid_rst_k", 32'(o_k), 32'd0);
    chk("mid_rst_rdy", 32'(o_ready), 32'd1);
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    repeat (6) @(negedge i_clk);
    chk("mid_rst_flush", 32'(o_valid), 32'd0);

    repeat (10000) begin
      @(posedge i_clk); #1;
      i_valid = 1'($urandom);
      i_ready = 1'($urandom);
      i_a = 8'($urandom);
      i_k = 3'($urandom);
    end
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (5) @(negedge i_clk);
    chk("sb_drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
